// File: rtl/reset_seq_pkg.sv
// Shared types for the power-on reset sequencer: FSM states,
// reset-cause encodings and a small elaboration helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_POR  = 2'b01,
        CAUSE_SOFT = 2'b10,
        CAUSE_WDT  = 2'b11
    } cause_t;

    function automatic int unsigned max2(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asynchronous assert, synchronous deassert.
// Reusable for any clock domain that needs a clean local reset.
module reset_sync (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            sync_rst_n <= 1'b0;
        end else begin
            meta       <= 1'b1;
            sync_rst_n <= meta;
        end
    end

endmodule

// File: rtl/por_reset_sequencer.sv
// Ordered release of per-domain resets after POR, soft reset or watchdog.
// Optional watchdog is built only when RESET_SEQ_WDT_EN is defined.
module por_reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned STAGE_GAP     = 4,
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned WDT_CYCLES    = 1024
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  soft_rst_req,
    input  logic                  wdt_kick,
    output logic [NUM_STAGES-1:0] rst_n_stage,
    output logic                  ready,
    output logic [1:0]            rst_cause,
    output logic                  wdt_fired
);

    localparam int unsigned CW = $clog2(max2(STABLE_CYCLES, STAGE_GAP)) + 1;
    localparam int unsigned IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_STAGES - 1);

    logic                  sync_rst_n;
    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [NUM_STAGES-1:0] stage_q, stage_nx;
    logic                  ready_q, ready_nx;
    cause_t                cause, cause_nx;
    logic                  wdt_expire;

    reset_sync u_sync (
        .clk        (clk),
        .rst_n      (resetb),
        .sync_rst_n (sync_rst_n)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state   <= WAIT_SYNC;
            cnt     <= '0;
            idx     <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            cause   <= CAUSE_POR;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            stage_q <= stage_nx;
            ready_q <= ready_nx;
            cause   <= cause_nx;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    localparam int unsigned WW = $clog2(WDT_CYCLES) + 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wdog, wdog_nx;
    logic          fired_q, fired_nx;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wdog    <= '0;
            fired_q <= 1'b0;
        end else begin
            wdog    <= wdog_nx;
            fired_q <= fired_nx;
        end
    end

    // Counts only while in RUN; a kick on the expiry edge wins.
    always_comb begin
        wdog_nx    = '0;
        fired_nx   = fired_q;
        wdt_expire = 1'b0;
        if (state == RUN) begin
            if (wdt_kick) begin
                wdog_nx = '0;
            end else if (wdog == WDT_LAST) begin
                wdt_expire = 1'b1;
                fired_nx   = 1'b1;
            end else begin
                wdog_nx = wdog + WW'(1);
            end
        end
    end

    assign wdt_fired = fired_q;
`else
    localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
    logic unused_kick;

    assign unused_kick = wdt_kick;
    assign wdt_expire  = 1'b0;
    assign wdt_fired   = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        stage_nx = stage_q;
        ready_nx = ready_q;
        cause_nx = cause;

        unique case (state)
            WAIT_SYNC: begin
                if (sync_rst_n) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end
            end
            STABLE: begin
                if (cnt == STABLE_LAST) begin
                    state_nx    = RELEASE;
                    stage_nx[0] = 1'b1;
                    idx_nx      = '0;
                    cnt_nx      = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (idx == IDX_LAST) begin
                    state_nx = RUN;
                    ready_nx = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    idx_nx   = idx + IW'(1);
                    stage_nx = stage_q | (NUM_STAGES'(1) << idx_nx);
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RUN: begin
                ready_nx = 1'b1;
            end
        endcase

        // Soft request outranks the watchdog for the reported cause.
        if (state != WAIT_SYNC && (soft_rst_req || wdt_expire)) begin
            state_nx = STABLE;
            cnt_nx   = '0;
            idx_nx   = '0;
            stage_nx = '0;
            ready_nx = 1'b0;
            cause_nx = soft_rst_req ? CAUSE_SOFT : CAUSE_WDT;
        end
    end

    assign rst_n_stage = stage_q;
    assign ready       = ready_q;
    assign rst_cause   = cause;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Scoreboard bench for por_reset_sequencer: timeline reference model,
// per-cycle expected outputs queued at posedge and checked at negedge.
module tb_por_reset_sequencer;

    localparam int S = 16;
    localparam int G = 4;
    localparam int N = 3;
    localparam int W = 1024;
    localparam int NEVER = 32'h3fff_ffff;
`ifdef RESET_SEQ_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetb = 1'b0;
    logic         soft_rst_req = 1'b0;
    logic         wdt_kick = 1'b0;
    logic [N-1:0] rst_n_stage;
    logic         ready;
    logic [1:0]   rst_cause;
    logic         wdt_fired;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [N-1:0] stages;
        logic         rdy;
        logic [1:0]   cause;
        logic         fired;
    } exp_t;

    exp_t exp_q[$];

    por_reset_sequencer #(
        .STABLE_CYCLES (S),
        .STAGE_GAP     (G),
        .NUM_STAGES    (N),
        .WDT_CYCLES    (W)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .soft_rst_req (soft_rst_req),
        .wdt_kick     (wdt_kick),
        .rst_n_stage  (rst_n_stage),
        .ready        (ready),
        .rst_cause    (rst_cause),
        .wdt_fired    (wdt_fired)
    );

    always #5 clk = ~clk;

    // Reference model: absolute edge timeline.
    // origin = edge at which stage 0 rises; everything else follows from it.
    int         n = 0;
    int         e1 = -1;
    int         origin = NEVER;
    int         last_kick = -1;
    int         run_e;
    int         base;
    bit         expire;
    logic [1:0] m_cause = 2'b01;
    logic       m_fired = 1'b0;

    function automatic exp_t expect_now();
        exp_t e;
        for (int k = 0; k < N; k++)
            e.stages[k] = (n >= origin + k * G);
        e.rdy   = (n >= origin + (N - 1) * G + 1);
        e.cause = m_cause;
        e.fired = m_fired;
        return e;
    endfunction

    always @(posedge clk) begin
        n++;
        if (!resetb) begin
            e1      = -1;
            origin  = NEVER;
            m_cause = 2'b01;
            m_fired = 1'b0;
        end else if (e1 < 0) begin
            e1     = n;
            origin = n + 2 + S;
        end else if (n >= e1 + 3) begin
            run_e  = origin + (N - 1) * G + 1;
            base   = (last_kick > run_e) ? last_kick : run_e;
            expire = WDT_ON && n > run_e && !wdt_kick && (n - base == W);
            if (WDT_ON && n > run_e && wdt_kick)
                last_kick = n;
            if (soft_rst_req || expire) begin
                origin  = n + S;
                m_cause = soft_rst_req ? 2'b10 : 2'b11;
                if (expire)
                    m_fired = 1'b1;
            end
        end
        exp_q.push_back(expect_now());
    end

    // An asynchronous reset overrides whatever the last edge promised.
    always @(negedge resetb) begin
        e1      = -1;
        origin  = NEVER;
        m_cause = 2'b01;
        m_fired = 1'b0;
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            exp_q.push_back(expect_now());
        end
    end

    exp_t m_e;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            checks++;
            if ({rst_n_stage, ready, rst_cause, wdt_fired} !== m_e) begin
                errors++;
                $display("FAIL outputs @%0t: got stages=%b ready=%b cause=%b fired=%b, expected stages=%b ready=%b cause=%b fired=%b",
                         $time, rst_n_stage, ready, rst_cause, wdt_fired,
                         m_e.stages, m_e.rdy, m_e.cause, m_e.fired);
            end
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cycles(input int k, input bit s, input bit kick);
        repeat (k) begin
            step();
            soft_rst_req = s;
            wdt_kick     = kick;
        end
    endtask

    task automatic wait_ready(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (ready) break;
        end
        check_val("ready_timeout", int'(ready), 1);
    endtask

    // Edges counted from E1; soft optionally held through E1..E3.
    task automatic por_seq(input string tag, input bit soft_in_sync);
        int first0;
        int firstr;
        step();
        resetb       = 1'b0;
        soft_rst_req = soft_in_sync;
        wdt_kick     = 1'b0;
        repeat (5) step();
        check_val({tag, "_low_ready"}, int'(ready), 0);
        check_val({tag, "_low_cause"}, int'(rst_cause), 1);
        step();
        resetb = 1'b1;
        first0 = 0;
        firstr = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) soft_rst_req = 1'b0;
            if (rst_n_stage[0] && first0 == 0) first0 = i;
            if (ready) begin
                firstr = i;
                break;
            end
        end
        check_val({tag, "_stage0_edge"}, first0, 3 + S);
        check_val({tag, "_ready_edge"}, firstr, 3 + S + (N - 1) * G + 1);
        check_val({tag, "_cause"}, int'(rst_cause), 1);
    endtask

    // Soft request held for `hold` edges starting at R; edges counted from R.
    task automatic soft_seq(input string tag, input int hold);
        int first0;
        int firstr;
        cycles(hold, 1'b1, 1'b0);
        step();
        soft_rst_req = 1'b0;
        first0 = 0;
        firstr = 0;
        for (int i = hold; i < hold + 60; i++) begin
            @(posedge clk);
            #1;
            if (rst_n_stage[0] && first0 == 0) first0 = i;
            if (ready) begin
                firstr = i;
                break;
            end
        end
        check_val({tag, "_stage0_edge"}, first0, hold - 1 + S);
        check_val({tag, "_ready_edge"}, firstr, hold - 1 + S + (N - 1) * G + 1);
        check_val({tag, "_cause"}, int'(rst_cause), 2);
    endtask

    task automatic glitch(input int d);
        @(posedge clk);
        #(d);
        resetb = 1'b0;
        #0.5;
        check_val("glitch_stages", int'(rst_n_stage), 0);
        check_val("glitch_ready", int'(ready), 0);
        #0.5;
        resetb = 1'b1;
    endtask

    initial begin
        por_seq("por", 1'b0);
        soft_seq("soft1", 1);
        soft_seq("soft_held", 10);
        por_seq("por_softsync", 1'b1);

        // Glitch mid-RELEASE with stage 0 already out.
        step();
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        check_val("glitch_pre_stage0", int'(rst_n_stage[0]), 1);
        check_val("glitch_pre_ready", int'(ready), 0);
        @(posedge clk);
        #2;
        resetb = 1'b0;
        #1;
        check_val("glitch_stages", int'(rst_n_stage), 0);
        check_val("glitch_cause", int'(rst_cause), 1);
        #1;
        resetb = 1'b1;
        wait_ready(60);

        // No kicks for well past the timeout.
        por_seq("por_nokick", 1'b0);
        cycles(1100, 1'b0, 1'b0);
        step();
        check_val("nokick_fired", int'(wdt_fired), int'(WDT_ON));
        check_val("nokick_cause", int'(rst_cause), WDT_ON ? 3 : 1);
        check_val("nokick_ready", int'(ready), 1);

        // Regular kicks, then a kick landing exactly on the expiry edge.
        por_seq("por_kick", 1'b0);
        repeat (3) begin
            cycles(999, 1'b0, 1'b0);
            cycles(1, 1'b0, 1'b1);
        end
        cycles(1, 1'b0, 1'b0);
        check_val("kick_fired", int'(wdt_fired), 0);
        por_seq("por_kickexp", 1'b0);
        cycles(1023, 1'b0, 1'b0);
        cycles(1, 1'b0, 1'b1);
        cycles(50, 1'b0, 1'b0);
        check_val("kickexp_fired", int'(wdt_fired), 0);
        check_val("kickexp_ready", int'(ready), 1);

        // Soft request coinciding with expiry.
        por_seq("por_coinc", 1'b0);
        cycles(1023, 1'b0, 1'b0);
        cycles(1, 1'b1, 1'b0);
        cycles(2, 1'b0, 1'b0);
        check_val("coinc_cause", int'(rst_cause), 2);
        check_val("coinc_fired", int'(wdt_fired), int'(WDT_ON));

        // Randomized mix; the scoreboard checks every cycle.
        repeat (40) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    repeat ($urandom_range(1, 60)) begin
                        step();
                        soft_rst_req = 1'b0;
                        wdt_kick     = ($urandom_range(0, 19) == 0);
                    end
                end
                5, 6: begin
                    cycles($urandom_range(1, 12), 1'b1, 1'b0);
                    cycles(1, 1'b0, 1'b0);
                end
                7: begin
                    glitch($urandom_range(1, 3));
                end
                8: begin
                    step();
                    resetb = 1'b0;
                    repeat ($urandom_range(1, 4)) begin
                        step();
                        soft_rst_req = $urandom_range(0, 1);
                    end
                    step();
                    resetb = 1'b1;
                    repeat (6) begin
                        step();
                        soft_rst_req = $urandom_range(0, 1);
                    end
                    soft_rst_req = 1'b0;
                end
                default: begin
                    cycles(1100, 1'b0, 1'b0);
                end
            endcase
        end
        cycles(40, 1'b0, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
